pipe_wb_stage: RTL

- Parametrised MEM/WB pipeline register plus writeback stage for the static-pipeline MIPS CPU.
- Latches MEM-stage results and selects the register-file data from 7 sources. Also selects the HI and LO write data.
- Extracts and sign/zero-extends byte and halfword loads.
- Holds the pipeline while a multi-cycle divide result is outstanding.

---
 rtl/pipe_wb_stage.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_wb_stage.sv
// MEM/WB pipeline register and writeback stage: selects RF/HI/LO write data and stalls on a pending divide.
// Optional byte/halfword load extraction is enabled with `define WB_LOAD_EXT_EN.
module pipe_wb_stage #(
    parameter int DATA_W   = 32,
    parameter int RN_W     = 5,
    parameter int WAIT_MAX = 40
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              en,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] dm,
    input  logic [DATA_W-1:0] pc4,
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] cp0,
    input  logic [DATA_W-1:0] counter,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] muler_hi,
    input  logic [DATA_W-1:0] muler_lo,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] r,
    input  logic [2:0]        rfsource,
    input  logic [1:0]        hisource,
    input  logic [1:0]        losource,
    input  logic [2:0]        ld_type,
    input  logic [1:0]        byte_off,
    input  logic [RN_W-1:0]   rn,
    input  logic              w_rf,
    input  logic              w_hi,
    input  logic              w_lo,
    input  logic              div_done,
    output logic              Ww_rf,
    output logic              Ww_hi,
    output logic              Ww_lo,
    output logic [DATA_W-1:0] Wdata_rf,
    output logic [DATA_W-1:0] Wdata_hi,
    output logic [DATA_W-1:0] Wdata_lo,
    output logic [RN_W-1:0]   Wrn,
    output logic              wb_busy,
    output logic              div_err
);

    localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    // Counter value in the last WAIT cycle before the abort; the entry cycle in IDLE also counts.
    localparam logic [WCNT_W-1:0] LAST_CNT = WCNT_W'((WAIT_MAX > 2) ? WAIT_MAX - 2 : 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] dm;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] cp0;
        logic [DATA_W-1:0] counter;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] muler_hi;
        logic [DATA_W-1:0] muler_lo;
        logic [DATA_W-1:0] q;
        logic [DATA_W-1:0] r;
        logic [2:0]        rfsource;
        logic [1:0]        hisource;
        logic [1:0]        losource;
        logic [RN_W-1:0]   rn;
        logic              w_rf;
        logic              w_hi;
        logic              w_lo;
    } stage_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    stage_t            stage_q, stage_d, stage_in, stage_bubble;
    logic              div_instr;
    logic              capture;
    logic [DATA_W-1:0] dm_sel;

    always_comb begin
        stage_in.alu      = alu;
        stage_in.dm       = dm;
        stage_in.pc4      = pc4;
        stage_in.hi       = hi;
        stage_in.lo       = lo;
        stage_in.cp0      = cp0;
        stage_in.counter  = counter;
        stage_in.a        = a;
        stage_in.muler_hi = muler_hi;
        stage_in.muler_lo = muler_lo;
        stage_in.q        = q;
        stage_in.r        = r;
        stage_in.rfsource = rfsource;
        stage_in.hisource = hisource;
        stage_in.losource = losource;
        stage_in.rn       = rn;
        stage_in.w_rf     = w_rf;
        stage_in.w_hi     = w_hi;
        stage_in.w_lo     = w_lo;
    end

    // A bubble only needs its write enables cleared; the data fields are don't-care.
    always_comb begin
        stage_bubble      = stage_q;
        stage_bubble.w_rf = 1'b0;
        stage_bubble.w_hi = 1'b0;
        stage_bubble.w_lo = 1'b0;
    end

    assign div_instr = (stage_q.w_hi && (stage_q.hisource == 2'd2)) ||
                       (stage_q.w_lo && (stage_q.losource == 2'd2));

    always_comb begin
        wb_busy = 1'b0;
        case (state_q)
            S_IDLE:  wb_busy = div_instr && !div_done;
            S_WAIT:  wb_busy = !div_done;
            default: wb_busy = 1'b0;
        endcase
    end

    assign capture = !wb_busy && !flush && en;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        stage_d = stage_q;
        div_err = 1'b0;
        if (wb_busy) begin
            if (flush) begin
                stage_d = stage_bubble;
                state_d = S_IDLE;
                wcnt_d  = '0;
            end else if ((state_q == S_WAIT) && (wcnt_q == LAST_CNT)) begin
                div_err = 1'b1;
                stage_d = stage_bubble;
                state_d = S_IDLE;
                wcnt_d  = '0;
            end else if (state_q == S_IDLE) begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end else begin
                wcnt_d = wcnt_q + WCNT_W'(1);
            end
        end else begin
            state_d = S_IDLE;
            wcnt_d  = '0;
            if (flush) begin
                stage_d = stage_bubble;
            end else if (capture) begin
                stage_d = stage_in;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            stage_q <= stage_d;
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [2:0]  ld_type_q, ld_type_d;
    logic [1:0]  byte_off_q, byte_off_d;
    logic [7:0]  dm_lane [4];
    logic [7:0]  dm_byte;
    logic [15:0] dm_half;
    logic [31:0] dm_word;

    always_comb begin
        ld_type_d  = capture ? ld_type : ld_type_q;
        byte_off_d = capture ? byte_off : byte_off_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ld_type_q  <= '0;
            byte_off_q <= '0;
        end else begin
            ld_type_q  <= ld_type_d;
            byte_off_q <= byte_off_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign dm_lane[gi] = stage_q.dm[8*gi +: 8];
    end

    always_comb begin
        dm_byte = dm_lane[byte_off_q];
        dm_half = byte_off_q[1] ? {dm_lane[3], dm_lane[2]} : {dm_lane[1], dm_lane[0]};
        case (ld_type_q)
            3'd1:    dm_word = {{24{dm_byte[7]}}, dm_byte};
            3'd2:    dm_word = {24'h0, dm_byte};
            3'd3:    dm_word = {{16{dm_half[15]}}, dm_half};
            3'd4:    dm_word = {16'h0, dm_half};
            default: dm_word = {dm_lane[3], dm_lane[2], dm_lane[1], dm_lane[0]};
        endcase
    end

    assign dm_sel = DATA_W'(dm_word);
`else
    logic unused_ld;
    assign unused_ld = ^{ld_type, byte_off};
    assign dm_sel    = stage_q.dm;
`endif

    always_comb begin
        case (stage_q.rfsource)
            3'd0:    Wdata_rf = stage_q.alu;
            3'd1:    Wdata_rf = dm_sel;
            3'd2:    Wdata_rf = stage_q.pc4;
            3'd3:    Wdata_rf = stage_q.hi;
            3'd4:    Wdata_rf = stage_q.lo;
            3'd5:    Wdata_rf = stage_q.cp0;
            3'd6:    Wdata_rf = stage_q.counter;
            default: Wdata_rf = '0;
        endcase
    end

    always_comb begin
        case (stage_q.hisource)
            2'd0:    Wdata_hi = stage_q.a;
            2'd1:    Wdata_hi = stage_q.muler_hi;
            2'd2:    Wdata_hi = stage_q.r;
            default: Wdata_hi = '0;
        endcase
        case (stage_q.losource)
            2'd0:    Wdata_lo = stage_q.a;
            2'd1:    Wdata_lo = stage_q.muler_lo;
            2'd2:    Wdata_lo = stage_q.q;
            default: Wdata_lo = '0;
        endcase
    end

    // Any stall cycle suppresses every write, including the IDLE cycle that raises the stall.
    assign Ww_rf = stage_q.w_rf && (|stage_q.rn) && (stage_q.rfsource != 3'd7) && !wb_busy;
    assign Ww_hi = stage_q.w_hi && (stage_q.hisource != 2'd3) && !wb_busy;
    assign Ww_lo = stage_q.w_lo && (stage_q.losource != 2'd3) && !wb_busy;
    assign Wrn   = stage_q.rn;

endmodule
